// File: rtl/pwm_duty_ramp_if.sv
// pwm_duty_ramp_if: duty request from the register file and ramped duty back to the PWM
//   target_duty/ramp_en/step_div/step_size : master -> slave
//   duty_out/busy/at_target/done_pulse     : slave -> master
interface pwm_duty_ramp_if #(parameter int WIDTH = 8, parameter int DIV_W = 8);
  logic [WIDTH-1:0] target_duty;
  logic             ramp_en;
  logic [DIV_W-1:0] step_div;
  logic [3:0]       step_size;
  logic [WIDTH-1:0] duty_out;
  logic             busy;
  logic             at_target;
  logic             done_pulse;
  modport master (output target_duty, ramp_en, step_div, step_size,
                  input duty_out, busy, at_target, done_pulse);
  modport slave (input target_duty, ramp_en, step_div, step_size,
                 output duty_out, busy, at_target, done_pulse);
endinterface

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: slew-rate limiter moving duty_out toward target_duty in timed steps
//   clk, rst (async, active-high); io.slave carries target_duty, ramp_en, step_div,
//   step_size in and duty_out, busy, at_target, done_pulse out.
//   Define DUTY_RAMP_IRQ_EN to build the done_pulse generator; otherwise it is tied to 0.
module pwm_duty_ramp #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 256,
  parameter int DIV_W    = 8
) (
  input logic clk,
  input logic rst,
  pwm_duty_ramp_if.slave io
);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic tick, step, up;
  logic [WIDTH:0] t, d, s, diff, nxt;
  // Extra bit keeps the step arithmetic free of wrap at either rail.
  assign t = {1'b0, io.target_duty};
  assign d = {1'b0, duty_q};
  assign s = (io.step_size == 4'd0) ? (WIDTH+1)'(1) : (WIDTH+1)'(io.step_size);
  assign up = (state_q == RAMP_UP);
  assign diff = up ? t - d : d - t;
  assign nxt = (diff <= s) ? t : up ? d + s : d - s;
  assign tick = (pre_q == PMAX);
  assign step = tick && (div_q == io.step_div);
  always_comb begin
    state_d = state_q;
    duty_d = duty_q;
    pre_d = '0;
    div_d = '0;
    if (state_q == IDLE) begin
      if (!io.ramp_en) duty_d = io.target_duty;
      else if (io.target_duty > duty_q) state_d = RAMP_UP;
      else if (io.target_duty < duty_q) state_d = RAMP_DOWN;
    end else if (!io.ramp_en) begin
      duty_d = io.target_duty;
      state_d = IDLE;
    end else if (duty_q == io.target_duty) begin
      state_d = IDLE;
    end else begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      div_d = tick ? (step ? '0 : div_q + 1'b1) : div_q;
      // A target that crossed to the other side flips direction without stepping.
      if (up != (io.target_duty > duty_q)) state_d = up ? RAMP_DOWN : RAMP_UP;
      else if (step) duty_d = nxt[WIDTH-1:0];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      duty_q <= '0;
      pre_q <= '0;
      div_q <= '0;
    end else begin
      state_q <= state_d;
      duty_q <= duty_d;
      pre_q <= pre_d;
      div_q <= div_d;
    end
  assign io.duty_out = duty_q;
  assign io.busy = (state_q != IDLE);
  assign io.at_target = (duty_q == io.target_duty);
`ifdef DUTY_RAMP_IRQ_EN
  logic done_q, done_d;
  assign done_d = (state_q != IDLE) && io.ramp_en && (duty_q == io.target_duty);
  always_ff @(posedge clk or posedge rst)
    if (rst) done_q <= 1'b0;
    else done_q <= done_d;
  assign io.done_pulse = done_q;
`else
  assign io.done_pulse = 1'b0;
`endif
endmodule
